// File: rtl/uart_frame_pkg.sv
// uart_frame_arbiter shared types and constants.
// Frame geometry, FSM state enum and frame timing helper.
package uart_frame_pkg;

  localparam int FRAME_W       = 40;
  localparam int BITS_PER_BYTE = 10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GO   = 2'd1,
    WAIT = 2'd2
  } ufa_state_e;

  function automatic int frame_cycles(
    input int cpb,
    input int bpf,
    input int gap
  );
    return cpb * (BITS_PER_BYTE * bpf + gap);
  endfunction

endpackage

// File: rtl/uart_frame_arbiter_if.sv
// Requester/transmitter bundle for uart_frame_arbiter.
// slave = arbiter side, master = requesters + transmitter side.
interface uart_frame_arbiter_if
  import uart_frame_pkg::*;
#(
  parameter int NUM_REQ = 4
) ();

  localparam int IDX_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]         req;
  logic [NUM_REQ*FRAME_W-1:0] frame_data;
  logic [NUM_REQ-1:0]         ack;
  logic                       trans_go;
  logic [FRAME_W-1:0]         data_out;
  logic [IDX_W-1:0]           grant_id;
  logic                       busy;

  modport master (
    output req,
    output frame_data,
    input  ack,
    input  trans_go,
    input  data_out,
    input  grant_id,
    input  busy
  );

  modport slave (
    input  req,
    input  frame_data,
    output ack,
    output trans_go,
    output data_out,
    output grant_id,
    output busy
  );

endinterface

// File: rtl/uart_frame_arbiter_rr_picker.sv
// Circular priority select from a pointer; with
// UFA_FIXED_PRIORITY_EN the pointer is ignored (lowest index wins).
module rr_picker #(
  parameter int N     = 4,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     i_req,
  input  logic [IDX_W-1:0] i_ptr,
  output logic [N-1:0]     o_onehot,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_valid
);

`ifdef UFA_FIXED_PRIORITY_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  int w_base;

  assign w_base = FIXED ? 0 : int'(i_ptr);

  // first requester found walking circularly from the base index
  always_comb begin
    logic [IDX_W-1:0] j;
    o_onehot = '0;
    o_idx    = '0;
    o_valid  = 1'b0;
    j        = '0;
    for (int k = 0; k < N; k++) begin
      j = IDX_W'((w_base + k) % N);
      if (!o_valid && i_req[j]) begin
        o_valid     = 1'b1;
        o_idx       = j;
        o_onehot[j] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_frame_arbiter.sv
// Shares one UART frame transmitter among NUM_REQ requesters.
// Round-robin by default; UFA_FIXED_PRIORITY_EN selects fixed priority.
module uart_frame_arbiter
  import uart_frame_pkg::*;
#(
  parameter int NUM_REQ         = 4,
  parameter int CLKS_PER_BIT    = 434,
  parameter int BYTES_PER_FRAME = 5,
  parameter int GAP_BITS        = 2
) (
  input  logic          sys_clk,
  input  logic          rst_n,
  uart_frame_arbiter_if.slave bus
);

  localparam int FC =
    frame_cycles(CLKS_PER_BIT, BYTES_PER_FRAME, GAP_BITS);
  localparam int CNT_W = $clog2(FC);
  localparam int IDX_W = $clog2(NUM_REQ);

  ufa_state_e         r_state, w_state_nx;
  logic [CNT_W-1:0]   r_cnt, w_cnt_nx;
  logic [FRAME_W-1:0] r_data, w_data_nx;
  logic [IDX_W-1:0]   r_gid, w_gid_nx;
  logic [NUM_REQ-1:0] r_ack, w_ack_nx;
  logic               r_go, w_go_nx;
  logic               r_busy, w_busy_nx;

  logic [IDX_W-1:0]   w_ptr;
  logic [NUM_REQ-1:0] w_win_oh;
  logic [IDX_W-1:0]   w_win_idx;
  logic               w_win_vld;
  logic [FRAME_W-1:0] w_frames [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_frm
    assign w_frames[g] =
      bus.frame_data[g*FRAME_W +: FRAME_W];
  end

`ifdef UFA_FIXED_PRIORITY_EN
  assign w_ptr = '0;
`else
  logic [IDX_W-1:0] r_ptr, w_ptr_nx;

  assign w_ptr = r_ptr;

  // next pointer sits just after the winner
  always_comb begin
    w_ptr_nx = r_ptr;
    if (r_state == IDLE && w_win_vld)
      w_ptr_nx =
        IDX_W'((int'(w_win_idx) + 1) % NUM_REQ);
  end

  // round-robin pointer register
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) r_ptr <= '0;
    else        r_ptr <= w_ptr_nx;
  end
`endif

  rr_picker #(
    .N     (NUM_REQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .i_req    (bus.req),
    .i_ptr    (w_ptr),
    .o_onehot (w_win_oh),
    .o_idx    (w_win_idx),
    .o_valid  (w_win_vld)
  );

  // grant, start pulse and frame timing decisions
  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_data_nx  = r_data;
    w_gid_nx   = r_gid;
    w_ack_nx   = '0;
    w_go_nx    = 1'b0;
    w_busy_nx  = r_busy;
    unique case (r_state)
      IDLE: begin
        if (w_win_vld) begin
          w_state_nx = GO;
          w_data_nx  = w_frames[w_win_idx];
          w_gid_nx   = w_win_idx;
          w_ack_nx   = w_win_oh;
          w_go_nx    = 1'b1;
          w_busy_nx  = 1'b1;
        end
      end
      GO: begin
        w_state_nx = WAIT;
        w_cnt_nx   = CNT_W'(FC - 1);
      end
      WAIT: begin
        if (r_cnt == '0) begin
          w_state_nx = IDLE;
          w_busy_nx  = 1'b0;
        end else begin
          w_cnt_nx = r_cnt - CNT_W'(1);
        end
      end
      default: begin
        w_state_nx = IDLE;
        w_busy_nx  = 1'b0;
      end
    endcase
  end

  // state, counter and registered outputs
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_data  <= '0;
      r_gid   <= '0;
      r_ack   <= '0;
      r_go    <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
      r_data  <= w_data_nx;
      r_gid   <= w_gid_nx;
      r_ack   <= w_ack_nx;
      r_go    <= w_go_nx;
      r_busy  <= w_busy_nx;
    end
  end

  assign bus.ack      = r_ack;
  assign bus.trans_go = r_go;
  assign bus.data_out = r_data;
  assign bus.grant_id = r_gid;
  assign bus.busy     = r_busy;

endmodule
